// File: rtl/instq_pkg.sv
// Shared definitions for the decoded-instruction dispatch buffer.
// Contents:
//   - field widths (OPC_W, REG_W, IMM_W, ADDR_W, PC_W)
//   - HLT_OPCODE, the {op,funct} value that starts the drain-then-halt sequence
//   - entry_t: one buffered instruction (106 bits, opcode in the MSBs, pc in the LSBs)
//   - state_t: dispatch FSM states
//   - is_hlt(): helper that tests an entry for the halt opcode
package instq_pkg;

  localparam int OPC_W  = 12;
  localparam int REG_W  = 5;
  localparam int IMM_W  = 16;
  localparam int ADDR_W = 26;
  localparam int PC_W   = 32;

  localparam logic [OPC_W-1:0] HLT_OPCODE = 12'hFC0;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  shamt;
    logic [IMM_W-1:0]  imm;
    logic [ADDR_W-1:0] addr;
    logic [PC_W-1:0]   pc;
  } entry_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  function automatic logic is_hlt(input entry_t e);
    return e.opcode == HLT_OPCODE;
  endfunction

endpackage

// File: rtl/dispatch_fifo_mem.sv
// Storage array for the dispatch buffer: DEPTH entries of entry_t.
// One synchronous write port and one asynchronous (combinational) read port,
// so the head entry is visible in the same cycle that rd_addr points at it.
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_addr  in   write index
//   wr_data  in   entry to store
//   rd_addr  in   read index (head pointer)
//   rd_data  out  entry at rd_addr
module dispatch_fifo_mem
  import instq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  entry_t        wr_data,
  input  logic [AW-1:0] rd_addr,
  output entry_t        rd_data
);

  entry_t mem [DEPTH];

  // Storage carries no reset: validity is tracked entirely by the top's count.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/inst_dispatch_buffer.sv
// Decoded-instruction dispatch buffer.
// Buffers decoded instructions in a FIFO, back-pressures the PC generator via
// fetch_stall, hands entries to dispatch with a valid/ready handshake, and
// drains then halts after a hlt instruction. flush empties it on a redirect.
// Optional feature macro: BYPASS_EN -- when defined, an instruction arriving at
// an empty buffer with out_ready high passes straight through combinationally.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid, in_*           decoded instruction from decode
//   fetch_stall              out: hold PC
//   flush                    discard everything, return to RUN
//   out_valid, out_ready     dispatch handshake
//   out_*                    head entry fields (0 when empty)
//   count                    occupancy 0..DEPTH
//   halted                   hlt dispatched, buffer idle
//   overflow_err             sticky: in_valid seen while full
module inst_dispatch_buffer
  import instq_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int STALL_MARGIN = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [OPC_W-1:0]      in_opcode,
  input  logic [REG_W-1:0]      in_rs,
  input  logic [REG_W-1:0]      in_rt,
  input  logic [REG_W-1:0]      in_rd,
  input  logic [REG_W-1:0]      in_shamt,
  input  logic [IMM_W-1:0]      in_imm,
  input  logic [ADDR_W-1:0]     in_addr,
  input  logic [PC_W-1:0]       in_pc,
  output logic                  fetch_stall,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OPC_W-1:0]      out_opcode,
  output logic [REG_W-1:0]      out_rs,
  output logic [REG_W-1:0]      out_rt,
  output logic [REG_W-1:0]      out_rd,
  output logic [REG_W-1:0]      out_shamt,
  output logic [IMM_W-1:0]      out_imm,
  output logic [ADDR_W-1:0]     out_addr,
  output logic [PC_W-1:0]       out_pc,
  output logic [$clog2(DEPTH):0] count,
  output logic                  halted,
  output logic                  overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  state_t          state_reg, state_next;
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            overflow_err_reg;

  entry_t          in_entry, rd_data, out_entry;
  logic            full, stored_valid, enq, deq, bypass, ovf_set;

  assign in_entry = '{opcode: in_opcode, rs: in_rs, rt: in_rt, rd: in_rd,
                      shamt: in_shamt, imm: in_imm, addr: in_addr, pc: in_pc};

  assign full         = (count_reg == CW'(DEPTH));
  assign stored_valid = (count_reg != '0) && (state_reg != HALTED);

`ifdef BYPASS_EN
  assign bypass = (count_reg == '0) && (state_reg == RUN) && in_valid && out_ready && !flush;
`else
  assign bypass = 1'b0;
`endif

  // A full buffer refuses new entries even if the head leaves this cycle.
  assign enq     = in_valid && !full && (state_reg == RUN) && !flush && !bypass;
  assign deq     = stored_valid && out_ready && !flush;
  assign ovf_set = in_valid && full && (state_reg == RUN) && !flush;

  dispatch_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .wr_en   (enq),
    .wr_addr (wr_ptr_reg),
    .wr_data (in_entry),
    .rd_addr (rd_ptr_reg),
    .rd_data (rd_data)
  );

  // Pointers, occupancy and the sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      overflow_err_reg <= 1'b0;
    end else if (flush) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      overflow_err_reg <= 1'b0;
    end else begin
      if (enq) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (deq) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({enq, deq})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      if (ovf_set) overflow_err_reg <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= RUN;
    else     state_reg <= state_next;
  end

  // FSM next state. Nothing is accepted after a hlt, so the hlt is always the
  // last entry to leave and the buffer is empty on entering HALTED.
  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = RUN;
    end else begin
      case (state_reg)
        RUN: begin
          if (bypass && is_hlt(in_entry))   state_next = HALTED;
          else if (enq && is_hlt(in_entry)) state_next = DRAIN;
        end
        DRAIN:   if (deq && is_hlt(rd_data)) state_next = HALTED;
        HALTED:  state_next = HALTED;
        default: state_next = RUN;
      endcase
    end
  end

  // FSM / datapath outputs.
  always_comb begin
    fetch_stall = (count_reg >= CW'(DEPTH - STALL_MARGIN)) || (state_reg != RUN);
    halted      = (state_reg == HALTED);
    out_valid   = stored_valid || bypass;
    out_entry   = '0;
    if (bypass)                  out_entry = in_entry;
    else if (count_reg != '0)    out_entry = rd_data;
  end

  assign out_opcode   = out_entry.opcode;
  assign out_rs       = out_entry.rs;
  assign out_rt       = out_entry.rt;
  assign out_rd       = out_entry.rd;
  assign out_shamt    = out_entry.shamt;
  assign out_imm      = out_entry.imm;
  assign out_addr     = out_entry.addr;
  assign out_pc       = out_entry.pc;
  assign count        = count_reg;
  assign overflow_err = overflow_err_reg;

endmodule

// File: tb/tb_inst_dispatch_buffer.sv
// Self-checking bench for inst_dispatch_buffer (DEPTH=8, STALL_MARGIN=2).
// A behavioural model tracks the buffer as a queue of expected entries;
// expected entries are pushed when the model accepts an instruction and
// popped/compared when the DUT dispatches one.
module tb_inst_dispatch_buffer;
  import instq_pkg::*;

  localparam int DEPTH = 8;
  localparam int MARGIN = 2;
  localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, flush, out_ready;
  logic [OPC_W-1:0]  in_opcode;
  logic [REG_W-1:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [IMM_W-1:0]  in_imm;
  logic [ADDR_W-1:0] in_addr;
  logic [PC_W-1:0]   in_pc;
  logic fetch_stall, out_valid, halted, overflow_err;
  logic [OPC_W-1:0]  out_opcode;
  logic [REG_W-1:0]  out_rs, out_rt, out_rd, out_shamt;
  logic [IMM_W-1:0]  out_imm;
  logic [ADDR_W-1:0] out_addr;
  logic [PC_W-1:0]   out_pc;
  logic [3:0]        count;

  int n_tests = 0;
  int n_fail  = 0;

  entry_t exp_q[$];
  int     m_state = M_RUN;
  logic   m_ovf = 1'b0;

  always #5 clk = ~clk;

  inst_dispatch_buffer #(.DEPTH(DEPTH), .STALL_MARGIN(MARGIN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_opcode(in_opcode),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_addr(in_addr), .in_pc(in_pc),
    .fetch_stall(fetch_stall), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_opcode(out_opcode), .out_rs(out_rs),
    .out_rt(out_rt), .out_rd(out_rd), .out_shamt(out_shamt),
    .out_imm(out_imm), .out_addr(out_addr), .out_pc(out_pc),
    .count(count), .halted(halted), .overflow_err(overflow_err)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic entry_t mk(input logic [11:0] opc, input int pc);
    entry_t e;
    e.opcode = opc;
    e.rs     = 5'(pc + 1);
    e.rt     = 5'(pc + 2);
    e.rd     = 5'(pc + 3);
    e.shamt  = 5'(pc * 3);
    e.imm    = 16'(16'h1000 + pc * 7);
    e.addr   = 26'(26'h0ABCDE + pc);
    e.pc     = 32'(pc);
    return e;
  endfunction

  function automatic entry_t dut_out();
    entry_t e;
    e = {out_opcode, out_rs, out_rt, out_rd, out_shamt, out_imm, out_addr, out_pc};
    return e;
  endfunction

  // One clock cycle: drive inputs, check registered outputs against the model,
  // handle dispatch/accept in the model, then advance past the next posedge.
  task automatic step(input logic iv, input entry_t e, input logic ordy, input logic fl);
    logic m_full, m_outv, m_byp, m_deq, m_enq;
    entry_t exp_e;
    in_valid = iv; out_ready = ordy; flush = fl;
    in_opcode = e.opcode; in_rs = e.rs; in_rt = e.rt; in_rd = e.rd;
    in_shamt = e.shamt; in_imm = e.imm; in_addr = e.addr; in_pc = e.pc;
    #2;
    m_full = (exp_q.size() == DEPTH);
    m_byp  = 1'b0;
`ifdef BYPASS_EN
    m_byp  = (exp_q.size() == 0) && (m_state == M_RUN) && iv && ordy && !fl;
`endif
    m_outv = ((exp_q.size() != 0) && (m_state != M_HALT)) || m_byp;
    check("count", 128'(count), 128'(exp_q.size()));
    check("out_valid", 128'(out_valid), 128'(m_outv));
    check("fetch_stall", 128'(fetch_stall),
          128'((exp_q.size() >= DEPTH - MARGIN) || (m_state != M_RUN)));
    check("overflow_err", 128'(overflow_err), 128'(m_ovf));
    check("halted", 128'(halted), 128'(m_state == M_HALT));
    if (exp_q.size() == 0 && !m_byp) check("out_zero", 128'(dut_out()), 128'(0));

    m_deq = (exp_q.size() != 0) && (m_state != M_HALT) && ordy && !fl;
    m_enq = iv && !m_full && (m_state == M_RUN) && !fl && !m_byp;
    if (m_byp) begin
      check("bypass_entry", 128'(dut_out()), 128'(e));
      $display("[TB] bypass   pc=%0d opcode=%h", out_pc, out_opcode);
      if (e.opcode == 12'hFC0) m_state = M_HALT;
    end
    if (m_deq) begin
      exp_e = exp_q.pop_front();
      check("dispatch_entry", 128'(dut_out()), 128'(exp_e));
      $display("[TB] dispatch pc=%0d opcode=%h", out_pc, out_opcode);
      if (exp_e.opcode == 12'hFC0 && m_state == M_DRAIN) m_state = M_HALT;
    end
    if (m_enq) begin
      exp_q.push_back(e);
      if (e.opcode == 12'hFC0) m_state = M_DRAIN;
    end
    if (iv && m_full && m_state == M_RUN && !fl) m_ovf = 1'b1;
    if (fl) begin
      exp_q.delete();
      m_state = M_RUN;
      m_ovf   = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  entry_t idle;
  localparam logic [11:0] ADDI = 12'h200, SW = 12'hAC0, LW = 12'h8C0, HLT = 12'hFC0;

  initial begin
    idle = '0;
    rst = 1'b1; in_valid = 0; flush = 0; out_ready = 0;
    in_opcode = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_shamt = 0;
    in_imm = 0; in_addr = 0; in_pc = 0;
    #1;
    check("rst_count", 128'(count), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_fetch_stall", 128'(fetch_stall), 128'(0));
    check("rst_halted", 128'(halted), 128'(0));
    check("rst_overflow", 128'(overflow_err), 128'(0));
    check("rst_out_pc", 128'(out_pc), 128'(0));
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // 1: three instructions in order, dispatch one cycle after enqueue
    step(1, mk(ADDI, 0), 1, 0);
    step(1, mk(SW, 1), 1, 0);
    step(1, mk(LW, 2), 1, 0);
    step(0, idle, 1, 0);
    step(0, idle, 1, 0);

    // 2: fill to full, one extra -> overflow, then flush clears the error
    for (int i = 0; i < 9; i++) step(1, mk(ADDI, 10 + i), 0, 0);
    step(0, idle, 0, 0);
    step(0, idle, 0, 1);
    step(0, idle, 0, 0);

    // 3: hlt drains then halts; instruction after hlt dropped without error
    step(1, mk(ADDI, 20), 0, 0);
    step(1, mk(HLT, 21), 0, 0);
    step(1, mk(ADDI, 22), 0, 0);
    for (int i = 0; i < 4; i++) step(1, mk(ADDI, 23 + i), 1, 0);
    step(0, idle, 0, 1);
    step(0, idle, 0, 0);

    // 4: flush with in_valid at count=5
    for (int i = 0; i < 5; i++) step(1, mk(LW, 30 + i), 0, 0);
    step(1, mk(SW, 99), 0, 1);
    step(0, idle, 0, 0);
    step(1, mk(SW, 40), 1, 0);
    step(0, idle, 1, 0);
    step(0, idle, 1, 0);

    // 5: steady in/out at count=4 across pointer wrap
    for (int i = 0; i < 4; i++) step(1, mk(ADDI, 50 + i), 0, 0);
    for (int i = 0; i < 12; i++) step(1, mk(SW, 60 + i), 1, 0);
    for (int i = 0; i < 5; i++) step(0, idle, 1, 0);

    // 6: asynchronous reset mid-stream at count=3
    for (int i = 0; i < 3; i++) step(1, mk(LW, 80 + i), 0, 0);
    in_valid = 0;
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_count", 128'(count), 128'(0));
    check("async_rst_out_valid", 128'(out_valid), 128'(0));
    check("async_rst_fetch_stall", 128'(fetch_stall), 128'(0));
    exp_q.delete(); m_state = M_RUN; m_ovf = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    step(1, mk(ADDI, 90), 1, 0);
    step(0, idle, 1, 0);

`ifdef BYPASS_EN
    // 7: pass-through on empty buffer, then bypassed hlt halts directly
    step(1, mk(SW, 100), 1, 0);
    step(1, mk(LW, 101), 1, 0);
    step(0, idle, 1, 0);
    step(1, mk(HLT, 102), 1, 0);
    step(0, idle, 1, 0);
    step(0, idle, 0, 1);
    step(0, idle, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
